// File: rtl/fwd_scoreboard.sv
// Operand-bypass network and load-use interlock for the ID stage.
// Tracks in-flight register writes in NSTAGE records (stage 0 = EX) and resolves each read port.
module fwd_scoreboard #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned NREAD      = 2,
  parameter int unsigned NSTAGE     = 3,
  parameter int unsigned LOAD_STAGE = 1
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      pipe_hold,
  input  logic                      id_valid,
  input  logic                      id_kill,
  input  logic [NREAD*REG_AW-1:0]   id_raddr,
  input  logic [NREAD*DATA_W-1:0]   id_rfdata,
  input  logic                      id_wen,
  input  logic [REG_AW-1:0]         id_waddr,
  input  logic [1:0]                id_kind,
  input  logic [DATA_W-1:0]         id_pc,
  input  logic [NSTAGE*DATA_W-1:0]  stage_data,
  output logic [NREAD*DATA_W-1:0]   fwd_data,
  output logic                      id_stall,
  output logic [15:0]               stall_cnt,
  output logic [15:0]               stall_evt
);

  typedef enum logic [1:0] {
    KIND_ALU  = 2'b00,
    KIND_LOAD = 2'b01,
    KIND_LINK = 2'b10,
    KIND_RSVD = 2'b11
  } kind_t;

  typedef enum logic {RUN, STALL} state_t;

  logic              rec_valid [NSTAGE];
  logic [REG_AW-1:0] rec_waddr [NSTAGE];
  kind_t             rec_kind  [NSTAGE];
  logic [DATA_W-1:0] rec_pc    [NSTAGE];

  logic [REG_AW-1:0] port_raddr [NREAD];
  logic              port_hit   [NREAD];
  logic [DATA_W-1:0] port_val   [NREAD];
  logic [NREAD-1:0]  not_ready;

  state_t state_q, state_d;
  logic   evt_inc;

  // Ascending scan with a hit flag: the youngest matching record claims the port and
  // older records are never consulted, even when the youngest is not ready yet.
  always_comb begin
    fwd_data  = '0;
    not_ready = '0;
    for (int unsigned p = 0; p < NREAD; p++) begin
      port_raddr[p] = id_raddr[p*REG_AW +: REG_AW];
      port_hit[p]   = 1'b0;
      port_val[p]   = (port_raddr[p] == '0) ? '0 : id_rfdata[p*DATA_W +: DATA_W];
      for (int unsigned s = 0; s < NSTAGE; s++) begin
        if (!port_hit[p] && rec_valid[s] && rec_waddr[s] == port_raddr[p] && port_raddr[p] != '0) begin
          port_hit[p]  = 1'b1;
          port_val[p]  = (rec_kind[s] == KIND_LINK) ? rec_pc[s] + DATA_W'(8)
                                                    : stage_data[s*DATA_W +: DATA_W];
          not_ready[p] = (rec_kind[s] == KIND_LOAD) && (s < LOAD_STAGE);
        end
      end
      fwd_data[p*DATA_W +: DATA_W] = resetn ? port_val[p] : '0;
    end
  end

  assign id_stall = resetn & (pipe_hold | (id_valid & ~id_kill & (|not_ready)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int unsigned s = 0; s < NSTAGE; s++) begin
        rec_valid[s] <= 1'b0;
        rec_waddr[s] <= '0;
        rec_kind[s]  <= KIND_ALU;
        rec_pc[s]    <= '0;
      end
    end else if (!pipe_hold) begin
      for (int unsigned s = 1; s < NSTAGE; s++) begin
        rec_valid[s] <= rec_valid[s-1];
        rec_waddr[s] <= rec_waddr[s-1];
        rec_kind[s]  <= rec_kind[s-1];
        rec_pc[s]    <= rec_pc[s-1];
      end
      rec_valid[0] <= id_valid & id_wen & ~id_kill & ~id_stall & (id_waddr != '0);
      rec_waddr[0] <= id_waddr;
      rec_kind[0]  <= kind_t'(id_kind);
      rec_pc[0]    <= id_pc;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (id_stall)  state_d = STALL;
      STALL:   if (!id_stall) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    evt_inc = (state_q == RUN) && id_stall;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_cnt <= '0;
      stall_evt <= '0;
    end else begin
      if (id_stall && stall_cnt != '1) stall_cnt <= stall_cnt + 16'd1;
      if (evt_inc && stall_evt != '1)  stall_evt <= stall_evt + 16'd1;
    end
  end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Directed and randomized checks of fwd_scoreboard against a record-list reference model.
module tb_fwd_scoreboard;
  localparam int DW = 32, AW = 5, NR = 2, NS = 3, LS = 1;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              pipe_hold = 1'b0, id_valid = 1'b0, id_kill = 1'b0, id_wen = 1'b0;
  logic [NR*AW-1:0]  id_raddr = '0;
  logic [NR*DW-1:0]  id_rfdata = '0;
  logic [AW-1:0]     id_waddr = '0;
  logic [1:0]        id_kind = '0;
  logic [DW-1:0]     id_pc = '0;
  logic [NS*DW-1:0]  stage_data = '0;
  logic [NR*DW-1:0]  fwd_data;
  logic              id_stall;
  logic [15:0]       stall_cnt, stall_evt;

  always #5 clk = ~clk;

  fwd_scoreboard #(.DATA_W(DW), .REG_AW(AW), .NREAD(NR), .NSTAGE(NS), .LOAD_STAGE(LS)) dut (
    .clk(clk), .resetn(resetn), .pipe_hold(pipe_hold), .id_valid(id_valid), .id_kill(id_kill),
    .id_raddr(id_raddr), .id_rfdata(id_rfdata), .id_wen(id_wen), .id_waddr(id_waddr),
    .id_kind(id_kind), .id_pc(id_pc), .stage_data(stage_data), .fwd_data(fwd_data),
    .id_stall(id_stall), .stall_cnt(stall_cnt), .stall_evt(stall_evt));

  typedef struct { bit v; bit [AW-1:0] a; bit [1:0] k; bit [DW-1:0] pc; } rec_t;
  rec_t        m [NS];
  int unsigned m_cnt, m_evt;
  bit          m_prev;
  logic [31:0] e_fwd [NR];
  bit          e_stall;
  int          nerr = 0, nchk = 0;
  logic [31:0] c0, e0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) m[s] = '{v: 1'b0, a: '0, k: '0, pc: '0};
    m_cnt = 0; m_evt = 0; m_prev = 1'b0;
  endtask

  // Newest entry first in m[]; first matching entry is the producer.
  task automatic model_eval();
    bit any_nr = 1'b0;
    for (int p = 0; p < NR; p++) begin
      logic [AW-1:0] ra = id_raddr[p*AW +: AW];
      int found = -1;
      for (int s = 0; s < NS; s++)
        if (found < 0 && m[s].v && m[s].a == ra && ra != 0) found = s;
      if (found < 0)               e_fwd[p] = (ra == 0) ? 32'h0 : id_rfdata[p*DW +: DW];
      else if (m[found].k == 2'b10) e_fwd[p] = m[found].pc + 32'd8;
      else                          e_fwd[p] = stage_data[found*DW +: DW];
      if (found >= 0 && m[found].k == 2'b01 && found < LS) any_nr = 1'b1;
    end
    e_stall = pipe_hold | (id_valid & !id_kill & any_nr);
  endtask

  task automatic model_adv();
    if (!pipe_hold) begin
      for (int s = NS-1; s > 0; s--) m[s] = m[s-1];
      m[0] = '{v: id_valid && id_wen && !id_kill && !e_stall && id_waddr != 0,
               a: id_waddr, k: id_kind, pc: id_pc};
    end
    if (e_stall && m_cnt != 32'hFFFF) m_cnt++;
    if (e_stall && !m_prev && m_evt != 32'hFFFF) m_evt++;
    m_prev = e_stall;
  endtask

  task automatic cycle();
    #1;
    model_eval();
    chk("fwd0", fwd_data[31:0], e_fwd[0]);
    chk("fwd1", fwd_data[63:32], e_fwd[1]);
    chk("stall", 32'(id_stall), 32'(e_stall));
    chk("stall_cnt", 32'(stall_cnt), m_cnt);
    chk("stall_evt", 32'(stall_evt), m_evt);
    @(posedge clk);
    model_adv();
    @(negedge clk);
  endtask

  task automatic issue(input logic wen, input logic [AW-1:0] wa, input logic [1:0] kind,
                       input logic [DW-1:0] pc);
    id_valid = 1'b1; id_kill = 1'b0; id_wen = wen; id_waddr = wa; id_kind = kind; id_pc = pc;
  endtask

  task automatic rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    id_raddr = {a1, a0};
  endtask

  initial begin
    model_reset();
    id_rfdata = {32'hDEAD_BEEF, 32'h1234_5678};
    rd(1, 2); issue(1'b1, 5'd1, 2'b01, 32'h0);
    #3;
    chk("rst_fwd", 32'(fwd_data[31:0] | fwd_data[63:32]), 32'h0);
    chk("rst_stall", 32'(id_stall), 32'h0);
    chk("rst_cnt", 32'(stall_cnt | stall_evt), 32'h0);
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;

    // ALU forward from EX
    issue(1'b1, 5'd3, 2'b00, 32'h100); rd(0, 0); cycle();
    issue(1'b0, 5'd0, 2'b00, 32'h104); rd(0, 3); stage_data[0 +: 32] = 32'h11;
    #1 chk("t1_fwd", fwd_data[63:32], 32'h11);
    cycle();

    // load-use: one stall then forward from MEM
    issue(1'b1, 5'd5, 2'b01, 32'h108); rd(0, 0); cycle();
    issue(1'b0, 5'd0, 2'b00, 32'h10C); rd(5, 0);
    #1 chk("t2_stall", 32'(id_stall), 32'h1);
    cycle();
    stage_data[32 +: 32] = 32'hCAFE;
    #1;
    chk("t2_fwd", fwd_data[31:0], 32'hCAFE);
    chk("t2_nostall", 32'(id_stall), 32'h0);
    chk("t2_cnt", 32'(stall_cnt), 32'h1);
    chk("t2_evt", 32'(stall_evt), 32'h1);
    cycle();

    // LINK producer shadowed by younger ALU, then LINK alone
    id_valid = 1'b0; repeat (3) cycle();
    issue(1'b1, 5'd31, 2'b10, 32'h400); rd(0, 0); cycle();
    issue(1'b1, 5'd31, 2'b00, 32'h404); cycle();
    id_valid = 1'b0; rd(31, 31); stage_data[0 +: 32] = 32'h7;
    #1 chk("t3_alu", fwd_data[31:0], 32'h7);
    cycle(); cycle();
    id_valid = 1'b0; rd(0, 0); repeat (3) cycle();
    issue(1'b1, 5'd31, 2'b10, 32'h400); cycle();
    id_valid = 1'b0; rd(31, 0);
    #1 chk("t3_link_ex", fwd_data[31:0], 32'h408);
    cycle();
    #1 chk("t3_link_mem", fwd_data[31:0], 32'h408);
    cycle();

    // r0 never tracked, reads as zero
    issue(1'b1, 5'd0, 2'b00, 32'h500); rd(0, 0); id_rfdata = '1; cycle();
    issue(1'b0, 5'd0, 2'b00, 32'h504);
    #1;
    chk("t4_fwd", fwd_data[31:0] | fwd_data[63:32], 32'h0);
    chk("t4_stall", 32'(id_stall), 32'h0);
    cycle();

    // pipe_hold with load in EX
    id_valid = 1'b0; repeat (3) cycle();
    issue(1'b1, 5'd2, 2'b01, 32'h600); rd(0, 0); cycle();
    issue(1'b0, 5'd0, 2'b00, 32'h604); rd(2, 0); pipe_hold = 1'b1;
    c0 = m_cnt; e0 = m_evt;
    repeat (3) cycle();
    pipe_hold = 1'b0;
    #1;
    chk("t5_cnt", 32'(stall_cnt), c0 + 32'd3);
    chk("t5_evt", 32'(stall_evt), e0 + 32'd1);
    cycle(); stage_data[32 +: 32] = $urandom; cycle();

    // async reset mid-stall with three records in flight
    issue(1'b1, 5'd1, 2'b00, 32'h700); rd(0, 0); cycle();
    issue(1'b1, 5'd2, 2'b00, 32'h704); cycle();
    issue(1'b1, 5'd3, 2'b01, 32'h708); cycle();
    issue(1'b0, 5'd0, 2'b00, 32'h70C); rd(3, 1);
    #1 chk("t6_stall", 32'(id_stall), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("t6_fwd", fwd_data[31:0] | fwd_data[63:32], 32'h0);
    chk("t6_stall0", 32'(id_stall), 32'h0);
    chk("t6_cnt", 32'(stall_cnt), 32'h0);
    chk("t6_evt", 32'(stall_evt), 32'h0);
    model_reset();
    @(negedge clk);
    resetn = 1'b1; id_rfdata = {32'hAAAA_0001, 32'h5555_0003};
    #1 chk("t6_rf", fwd_data[63:32], 32'hAAAA_0001);
    cycle();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      pipe_hold  = ($urandom % 8) == 0;
      id_valid   = ($urandom % 4) != 0;
      id_kill    = ($urandom % 8) == 0;
      id_wen     = ($urandom % 4) != 0;
      id_waddr   = AW'($urandom % 4);
      id_kind    = 2'($urandom);
      id_pc      = $urandom & 32'hFFFF_FFFC;
      rd(AW'($urandom % 4), AW'($urandom % 4));
      id_rfdata  = {$urandom, $urandom};
      stage_data = {$urandom, $urandom, $urandom};
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
